// File: rtl/ysyx_23060240_lsu_sram_pkg.sv
// Shared AXI4-Lite response codes and FSM state encodings for the LSU-side SRAM model.
package ysyx_23060240_lsu_sram_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_WAIT = 2'd1,
    R_RESP = 2'd2
  } r_state_t;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_WAIT = 2'd1,
    W_RESP = 2'd2
  } w_state_t;

endpackage

// File: rtl/ysyx_23060240_lfsr8.sv
// 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1), seed 8'hA5, advances every cycle.
// Only compiled when LSU_SRAM_RAND_DELAY_EN is defined.
`ifdef LSU_SRAM_RAND_DELAY_EN
module ysyx_23060240_lfsr8 (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] out
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) out <= 8'hA5;
    else     out <= {out[6:0], out[7] ^ out[5] ^ out[4] ^ out[3]};
  end

endmodule
`endif

// File: rtl/ysyx_23060240_lsu_sram.sv
// AXI4-Lite slave SRAM for the LSU; random delay option under LSU_SRAM_RAND_DELAY_EN.
// Latency: response valid 1+D cycles after the (later) address/data handshake, D=LATENCY or LFSR.
// Backpressure: responses held stable until rready/bready; no new request accepted meanwhile.
module ysyx_23060240_lsu_sram
  import ysyx_23060240_lsu_sram_pkg::*;
#(
  parameter int          DEPTH   = 1024,
  parameter logic [31:0] BASE    = 32'h8000_0000,
  parameter int          LATENCY = 2,
  parameter int          DLY_W   = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rvalid,
  input  logic        rready,
  input  logic [31:0] awaddr,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wvalid,
  output logic        wready,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = ($clog2(LATENCY + 1) > DLY_W) ? $clog2(LATENCY + 1) : DLY_W;

  logic [CW-1:0] dly;
`ifdef LSU_SRAM_RAND_DELAY_EN
  logic [7:0] lfsr;
  ysyx_23060240_lfsr8 u_lfsr (.clk(clk), .rst(rst), .out(lfsr));
  assign dly = CW'(lfsr[DLY_W-1:0]);
`else
  assign dly = CW'(LATENCY);
`endif

  logic [31:0] mem [0:DEPTH-1];

  // ---------------- read engine ----------------
  r_state_t      r_state, r_state_n;
  logic [31:0]   raddr_q, r_addr_eff, r_off, r_word;
  logic [CW-1:0] rcnt;
  logic          r_hs, r_sample, r_ok;

  assign arready    = (r_state == R_IDLE);
  assign rvalid     = (r_state == R_RESP);
  assign r_hs       = arvalid && arready;
  assign r_addr_eff = (r_state == R_IDLE) ? araddr : raddr_q;
  assign r_off      = r_addr_eff - BASE;
  assign r_word     = r_off >> 2;
  assign r_ok       = (r_addr_eff >= BASE) && (r_word < 32'(DEPTH));

  // Zero delay samples straight from the handshake so rvalid lands at t+1.
  always_comb begin
    r_state_n = r_state;
    r_sample  = 1'b0;
    case (r_state)
      R_IDLE: if (r_hs) begin
        if (dly == '0) begin
          r_sample  = 1'b1;
          r_state_n = R_RESP;
        end else begin
          r_state_n = R_WAIT;
        end
      end
      R_WAIT: if (rcnt == '0) begin
        r_sample  = 1'b1;
        r_state_n = R_RESP;
      end
      R_RESP: if (rready) r_state_n = R_IDLE;
      default: r_state_n = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= R_IDLE;
      raddr_q <= '0;
      rcnt    <= '0;
      rdata   <= '0;
      rresp   <= RESP_OKAY;
    end else begin
      r_state <= r_state_n;
      if (r_hs) raddr_q <= araddr;
      if (r_hs && dly != '0)                rcnt <= dly - 1'b1;
      else if (r_state == R_WAIT && rcnt != '0) rcnt <= rcnt - 1'b1;
      if (r_sample) begin
        rdata <= r_ok ? mem[r_word[AW-1:0]] : 32'h0;
        rresp <= r_ok ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  // ---------------- write engine ----------------
  w_state_t      w_state, w_state_n;
  logic [31:0]   awaddr_q, wdata_q, w_addr_eff, w_data_eff, w_off, w_word;
  logic [3:0]    wstrb_q, w_strb_eff;
  logic [CW-1:0] wcnt;
  logic          aw_got, w_got, aw_hs, w_hs, w_commit, w_ok;

  assign awready    = (w_state == W_IDLE) && !aw_got;
  assign wready     = (w_state == W_IDLE) && !w_got;
  assign bvalid     = (w_state == W_RESP);
  assign aw_hs      = awvalid && awready;
  assign w_hs       = wvalid && wready;
  assign w_addr_eff = aw_got ? awaddr_q : awaddr;
  assign w_data_eff = w_got ? wdata_q : wdata;
  assign w_strb_eff = w_got ? wstrb_q : wstrb;
  assign w_off      = w_addr_eff - BASE;
  assign w_word     = w_off >> 2;
  assign w_ok       = (w_addr_eff >= BASE) && (w_word < 32'(DEPTH));

  always_comb begin
    w_state_n = w_state;
    w_commit  = 1'b0;
    case (w_state)
      W_IDLE: if ((aw_got || aw_hs) && (w_got || w_hs)) begin
        if (dly == '0) begin
          w_commit  = 1'b1;
          w_state_n = W_RESP;
        end else begin
          w_state_n = W_WAIT;
        end
      end
      W_WAIT: if (wcnt == '0) begin
        w_commit  = 1'b1;
        w_state_n = W_RESP;
      end
      W_RESP: if (bready) w_state_n = W_IDLE;
      default: w_state_n = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state  <= W_IDLE;
      aw_got   <= 1'b0;
      w_got    <= 1'b0;
      awaddr_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      wcnt     <= '0;
      bresp    <= RESP_OKAY;
    end else begin
      w_state <= w_state_n;
      if (aw_hs) begin
        awaddr_q <= awaddr;
        aw_got   <= 1'b1;
      end
      if (w_hs) begin
        wdata_q <= wdata;
        wstrb_q <= wstrb;
        w_got   <= 1'b1;
      end
      if (w_state == W_RESP && bready) begin
        aw_got <= 1'b0;
        w_got  <= 1'b0;
      end
      if (w_state == W_IDLE && w_state_n == W_WAIT) wcnt <= dly - 1'b1;
      else if (w_state == W_WAIT && wcnt != '0)     wcnt <= wcnt - 1'b1;
      if (w_commit) bresp <= w_ok ? RESP_OKAY : RESP_SLVERR;
    end
  end

  // Non-blocking commit: a same-cycle read sample sees the pre-write word.
  always_ff @(posedge clk) begin
    if (w_commit && w_ok) begin
      for (int i = 0; i < 4; i++) begin
        if (w_strb_eff[i]) mem[w_word[AW-1:0]][8*i +: 8] <= w_data_eff[8*i +: 8];
      end
    end
  end

endmodule
